nixie_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a bank of NUM_DIGITS ten-cathode display tubes (nixie-style).

---
 rtl/nixie_pkg.sv | 20 ++
 rtl/decoder_bcd2decimal.sv | 16 +
 rtl/nixie_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_nixie_scan_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/nixie_pkg.sv
// Shared widths, state encoding and helpers for the nixie tube scan controller.
package nixie_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned DEC_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/decoder_bcd2decimal.sv
// BCD digit to one-hot decimal cathode select; codes above 9 decode to all-off.
module decoder_bcd2decimal
    import nixie_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [DEC_W-1:0] dec_o_c
);

    always_comb begin
        dec_o_c = '0;
        if (bcd_i < BCD_W'(10)) begin
            dec_o_c = DEC_W'(1) << bcd_i;
        end
    end

endmodule

// File: rtl/nixie_scan_ctrl.sv
// Multiplexed scan controller for a bank of ten-cathode tubes: double-buffered
// BCD frame, per-digit ON phase followed by an anti-ghosting blank gap.
module nixie_scan_ctrl
    import nixie_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned ON_CYCLES    = 1000,
    parameter int unsigned BLANK_CYCLES = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_data,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [DEC_W-1:0]              cathode,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int unsigned FRAME_W = BCD_W * NUM_DIGITS;
    localparam int unsigned DIG_W   = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W   = $clog2(max3(ON_CYCLES, BLANK_CYCLES, 2));

    localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK_CYCLES == 0) ? '0
                                                                 : CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DIG_W-1:0] LAST_DIG   = DIG_W'(NUM_DIGITS - 1);
    // Phase whose last clock closes a frame.
    localparam state_e           LAST_ST    = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

    state_e                state_q, state_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_W-1:0]    active_q, active_d;
    logic [FRAME_W-1:0]    shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  xfer_q;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [DEC_W-1:0]      cathode_q, cathode_d;
    logic                  frame_done_q, frame_done_d;
    logic                  load_ready_q;

    logic [DIG_W-1:0]      next_digit_c;
    logic                  xfer_c;
    logic                  commit_c;
    logic [BCD_W-1:0]      nibble_c;
    logic [DEC_W-1:0]      dec_c;

    assign next_digit_c = (digit_q == LAST_DIG) ? '0 : digit_q + DIG_W'(1);

    // Scan sequencing; a low enable always wins and parks the scan at digit 0.
    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        anode_d      = '0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_ON;
                digit_d = '0;
                cnt_d   = ON_LOAD;
            end
            ST_ON: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (BLANK_CYCLES == 0) begin
                    digit_d = next_digit_c;
                    cnt_d   = ON_LOAD;
                end else begin
                    state_d = ST_BLANK;
                    cnt_d   = BLANK_LOAD;
                end
            end
            ST_BLANK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_ON;
                    digit_d = next_digit_c;
                    cnt_d   = ON_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                digit_d = '0;
                cnt_d   = '0;
            end
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
            digit_d = '0;
            cnt_d   = '0;
        end

        frame_done_d = (state_d == LAST_ST) && (digit_d == LAST_DIG) && (cnt_d == '0);
        if (state_d == ST_ON) begin
            anode_d = NUM_DIGITS'(1) << digit_d;
        end
    end

    // Shadow accepts a frame when empty; it is promoted only at a frame
    // boundary, or straight away if the transfer landed while idle.
    assign xfer_c    = load_valid && load_ready_q;
    assign commit_c  = pending_q && (frame_done_q || ((state_q == ST_IDLE) && xfer_q));
    assign active_d  = commit_c ? shadow_q : active_q;
    assign shadow_d  = xfer_c ? load_data : shadow_q;
    assign pending_d = xfer_c || (pending_q && !commit_c);

    // Decode from next-cycle frame/digit so anode and cathode update together.
    assign nibble_c  = active_d[32'(digit_d) * BCD_W +: BCD_W];

    decoder_bcd2decimal u_dec (
        .bcd_i   (nibble_c),
        .dec_o_c (dec_c)
    );

    assign cathode_d = (state_d == ST_ON) ? dec_c : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            digit_q      <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            xfer_q       <= 1'b0;
            anode_q      <= '0;
            cathode_q    <= '0;
            frame_done_q <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            xfer_q       <= xfer_c;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            frame_done_q <= frame_done_d;
            load_ready_q <= !pending_d;
        end
    end

    assign load_ready = load_ready_q;
    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign digit_idx  = digit_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nixie_scan_ctrl.sv
// Randomised scoreboard bench for nixie_scan_ctrl against a frame-time reference model.
module tb_nixie_scan_ctrl;

    localparam int N     = 4;
    localparam int ON    = 3;
    localparam int BL    = 1;
    localparam int P     = ON + BL;
    localparam int FRAME = N * P;

    typedef struct packed {
        logic [3:0] anode;
        logic [9:0] cathode;
        logic [1:0] digit;
        logic       fd;
        logic       ready;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  anode;
    logic [9:0]  cathode;
    logic [1:0]  digit_idx;
    logic        frame_done;

    nixie_scan_ctrl #(
        .NUM_DIGITS   (N),
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .anode      (anode),
        .cathode    (cathode),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: m_t is the clock position within the frame, -1 when idle.
    int          m_t         = -1;
    logic [15:0] m_active    = '0;
    logic [15:0] m_shadow    = '0;
    bit          m_pending   = 1'b0;
    bit          m_xfer_prev = 1'b0;

    // Advance the model across the coming edge with the inputs now driven,
    // queue the outputs expected after that edge, then wait for the next negedge.
    task automatic step();
        exp_t        e;
        int          dig;
        bit          lit;
        bit          idle_now;
        bit          fd_now;
        bit          xfer;
        logic [3:0]  nib;
        if (rst) begin
            m_t         = -1;
            m_active    = '0;
            m_shadow    = '0;
            m_pending   = 1'b0;
            m_xfer_prev = 1'b0;
        end else begin
            idle_now = (m_t < 0);
            fd_now   = !idle_now && (m_t == FRAME - 1);
            xfer     = load_valid && !m_pending;
            if (m_pending && (fd_now || (idle_now && m_xfer_prev))) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (xfer) begin
                m_shadow  = load_data;
                m_pending = 1'b1;
            end
            m_xfer_prev = xfer;
            m_t = enable ? ((m_t + 1) % FRAME) : -1;
        end

        e = '0;
        e.ready = !m_pending;
        if (m_t >= 0) begin
            dig     = m_t / P;
            lit     = (m_t % P) < ON;
            nib     = m_active[dig*4 +: 4];
            e.digit = 2'(dig);
            e.fd    = (m_t == FRAME - 1);
            if (lit) begin
                e.anode = 4'(1) << dig;
                if (nib < 4'd10) e.cathode = 10'(1) << nib;
            end
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_pos(input int pos);
        for (int i = 0; i < 2 * FRAME && m_t != pos; i++) step();
    endtask

    task automatic offer(input logic [15:0] d);
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
    endtask

    // Monitor: every clock presents a full output word; pop and compare.
    initial begin
        exp_t e;
        exp_t act;
        int   cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            act = '{anode, cathode, digit_idx, frame_done, load_ready};
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow cyc%0d: output seen with no expectation queued", cyc);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL scan cyc%0d: got anode=%b cathode=%h digit=%0d fd=%b ready=%b, want anode=%b cathode=%h digit=%0d fd=%b ready=%b",
                             cyc, act.anode, act.cathode, act.digit, act.fd, act.ready,
                             e.anode, e.cathode, e.digit, e.fd, e.ready);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        run(2);
        rst = 1'b0;
        step();

        // Idle load commits immediately; then two full frames of 1234.
        offer(16'h1234);
        run(2);
        enable = 1'b1;
        run(2 * FRAME + 4);

        // Out-of-range nibble on digit 1.
        offer(16'h00F0);
        run(2 * FRAME);

        // Mid-frame load held off until the frame boundary.
        run_until_pos(4);
        offer(16'h9999);
        load_valid = 1'b1;
        load_data  = 16'h4321;
        run(3);
        load_valid = 1'b0;
        run(2 * FRAME);

        // Disable during digit 2 ON, then restart.
        run_until_pos(8);
        enable = 1'b0;
        run(4);
        enable = 1'b1;
        run(FRAME + 2);

        // Reset with a frame pending mid-scan.
        run_until_pos(2);
        offer(16'h5678);
        run(2);
        rst    = 1'b1;
        enable = 1'b0;
        run(2);
        rst = 1'b0;
        step();
        enable = 1'b1;
        run(FRAME + 4);

        // Random traffic: sporadic enable toggles, offers, data and resets.
        for (int i = 0; i < 1200; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) enable = !enable;
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom);
            step();
        end
        rst        = 1'b0;
        load_valid = 1'b0;
        run(4);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
